// File: rtl/cpu_bus_ctrl_if.sv
// CPU-side bus of cpu_bus_ctrl: 6502 address, write strobe and data,
// plus the read-data return and the DMA stall line back to the core.
interface cpu_bus_ctrl_if;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_rdy;

    modport master (
        output cpu_addr,
        output cpu_we,
        output cpu_din,
        input  cpu_dout,
        input  cpu_rdy
    );

    modport slave (
        input  cpu_addr,
        input  cpu_we,
        input  cpu_din,
        output cpu_dout,
        output cpu_rdy
    );
endinterface

// File: rtl/cpu_bus_ctrl.sv
// CPU memory-map controller: mirrored work RAM, UxROM PRG banking, PPU register window,
// NES controller shift registers and a CPU-stalling OAM DMA engine. Define
// CPU_BUS_CTRL_CTRL2_EN to add the second controller port at $4017.
module cpu_bus_ctrl #(
    parameter int RAM_AW    = 11,
    parameter int BANK_BITS = 3,
    parameter int DMA_LEN   = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    cpu_bus_ctrl_if.slave          cpu,
    output logic [RAM_AW-1:0]      ram_addr,
    output logic                   ram_we,
    output logic [7:0]             ram_din,
    input  logic [7:0]             ram_dout,
    output logic [BANK_BITS+13:0]  prg_addr,
    input  logic [7:0]             prg_dout,
    output logic                   ppu_reg_cs,
    output logic [2:0]             ppu_reg_addr,
    output logic                   ppu_reg_we,
    output logic [7:0]             ppu_reg_din,
    input  logic [7:0]             ppu_reg_dout,
    output logic                   oam_we,
    output logic [7:0]             oam_addr,
    output logic [7:0]             oam_din,
    input  logic [7:0]             keystates
`ifdef CPU_BUS_CTRL_CTRL2_EN
    ,
    input  logic [7:0]             keystates2
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ALIGN = 2'd1;
    localparam logic [1:0] ST_RD    = 2'd2;
    localparam logic [1:0] ST_WR    = 2'd3;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    typedef enum logic [2:0] {
        SEL_OPEN,
        SEL_RAM,
        SEL_PRG,
        SEL_PPU,
        SEL_CTRL
    } sel_t;

    logic [1:0]           state_q, state_d;
    logic [7:0]           page_q, page_d;
    logic [7:0]           idx_q, idx_d;
    logic [BANK_BITS-1:0] bank_q, bank_d;
    logic                 strobe_q, strobe_d;
    logic [7:0]           shift_q, shift_d;
    sel_t                 sel_q, sel_d;
    logic                 ctrl_bit_q, ctrl_bit_d;
`ifdef CPU_BUS_CTRL_CTRL2_EN
    logic [7:0]           shift2_q, shift2_d;
    logic                 is_ctrl2;
`endif

    logic                 busy;
    logic                 cpu_wr;
    logic                 cpu_rd;
    logic [15:0]          eff_addr;
    logic                 is_ram, is_ppu, is_prg, is_dma, is_ctrl1;
    logic [BANK_BITS-1:0] bank_sel;
    logic [7:0]           rd_data;

    // While DMA owns the bus the CPU is stalled, so its strobes and address are ignored.
    assign busy     = (state_q != ST_IDLE);
    assign eff_addr = busy ? {page_q, idx_q} : cpu.cpu_addr;
    assign cpu_wr   = !busy && cpu.cpu_we;
    assign cpu_rd   = !busy && !cpu.cpu_we;

    assign is_ram   = (eff_addr[15:13] == 3'b000);
    assign is_ppu   = (eff_addr[15:13] == 3'b001);
    assign is_prg   = eff_addr[15];
    assign is_dma   = (eff_addr == 16'h4014);
    assign is_ctrl1 = (eff_addr == 16'h4016);
`ifdef CPU_BUS_CTRL_CTRL2_EN
    assign is_ctrl2 = (eff_addr == 16'h4017);
`endif

    // The upper 16 KB window is hard-wired to the last bank.
    assign bank_sel = eff_addr[14] ? {BANK_BITS{1'b1}} : bank_q;

    // Address-side outputs
    assign ram_addr     = eff_addr[RAM_AW-1:0];
    assign ram_we       = cpu_wr && is_ram;
    assign ram_din      = cpu.cpu_din;
    assign prg_addr     = {bank_sel, eff_addr[13:0]};
    assign ppu_reg_cs   = !busy && is_ppu;
    assign ppu_reg_addr = eff_addr[2:0];
    assign ppu_reg_we   = cpu_wr && is_ppu;
    assign ppu_reg_din  = cpu.cpu_din;

    assign oam_we       = (state_q == ST_WR);
    assign oam_addr     = (state_q == ST_WR) ? idx_q : 8'h00;
    assign oam_din      = (state_q == ST_WR) ? rd_data : 8'h00;

    assign cpu.cpu_rdy  = !busy;
    assign cpu.cpu_dout = rd_data;

    // Read select registered so it lines up with the 1-cycle latency of the sources.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it
        // holding its old value, which would infer a latch.
        sel_d      = SEL_OPEN;
        ctrl_bit_d = 1'b0;
        if (is_ram) begin
            sel_d = SEL_RAM;
        end else if (is_prg) begin
            sel_d = SEL_PRG;
        end else if (!busy) begin
            if (is_ppu) begin
                sel_d = SEL_PPU;
            end else if (is_ctrl1) begin
                sel_d      = SEL_CTRL;
                ctrl_bit_d = strobe_q ? keystates[0] : shift_q[0];
            end
`ifdef CPU_BUS_CTRL_CTRL2_EN
            else if (is_ctrl2) begin
                sel_d      = SEL_CTRL;
                ctrl_bit_d = strobe_q ? keystates2[0] : shift2_q[0];
            end
`endif
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (sel_q)
            SEL_RAM:  rd_data = ram_dout;
            SEL_PRG:  rd_data = prg_dout;
            SEL_PPU:  rd_data = ppu_reg_dout;
            SEL_CTRL: rd_data = {7'b0, ctrl_bit_q};
            default:  rd_data = 8'h00;
        endcase
    end

    // Controller strobe/shift; a strobed register reloads every cycle and never shifts.
    always_comb begin
        strobe_d = strobe_q;
        if (cpu_wr && is_ctrl1) begin
            strobe_d = cpu.cpu_din[0];
        end

        shift_d = shift_q;
        if (strobe_q) begin
            shift_d = keystates;
        end else if (cpu_rd && is_ctrl1) begin
            shift_d = {1'b1, shift_q[7:1]};
        end

`ifdef CPU_BUS_CTRL_CTRL2_EN
        shift2_d = shift2_q;
        if (strobe_q) begin
            shift2_d = keystates2;
        end else if (cpu_rd && is_ctrl2) begin
            shift2_d = {1'b1, shift2_q[7:1]};
        end
`endif
    end

    always_comb begin
        bank_d = bank_q;
        if (cpu_wr && is_prg) begin
            bank_d = cpu.cpu_din[BANK_BITS-1:0];
        end
    end

    // OAM DMA: one alignment cycle, then a read/write pair per byte.
    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_wr && is_dma) begin
                    page_d  = cpu.cpu_din;
                    idx_d   = 8'h00;
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: state_d = ST_RD;
            ST_RD:    state_d = ST_WR;
            ST_WR: begin
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == LAST_IDX) ? ST_IDLE : ST_RD;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            page_q     <= 8'h00;
            idx_q      <= 8'h00;
            bank_q     <= '0;
            strobe_q   <= 1'b0;
            shift_q    <= 8'h00;
            sel_q      <= SEL_OPEN;
            ctrl_bit_q <= 1'b0;
`ifdef CPU_BUS_CTRL_CTRL2_EN
            shift2_q   <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            page_q     <= page_d;
            idx_q      <= idx_d;
            bank_q     <= bank_d;
            strobe_q   <= strobe_d;
            shift_q    <= shift_d;
            sel_q      <= sel_d;
            ctrl_bit_q <= ctrl_bit_d;
`ifdef CPU_BUS_CTRL_CTRL2_EN
            shift2_q   <= shift2_d;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl with RAM/PRG/PPU models and a scoreboard of
// expected read and OAM bytes; builds with or without CPU_BUS_CTRL_CTRL2_EN.
module tb_cpu_bus_ctrl;
    localparam int RAM_AW    = 11;
    localparam int BANK_BITS = 3;
    localparam int DMA_LEN   = 256;
    localparam int PRG_AW    = BANK_BITS + 14;

    logic                clk = 1'b0;
    logic                reset;
    logic [RAM_AW-1:0]   ram_addr;
    logic                ram_we;
    logic [7:0]          ram_din;
    logic [7:0]          ram_dout;
    logic [PRG_AW-1:0]   prg_addr;
    logic [7:0]          prg_dout;
    logic                ppu_reg_cs;
    logic [2:0]          ppu_reg_addr;
    logic                ppu_reg_we;
    logic [7:0]          ppu_reg_din;
    logic [7:0]          ppu_reg_dout;
    logic                oam_we;
    logic [7:0]          oam_addr;
    logic [7:0]          oam_din;
    logic [7:0]          keystates;
    logic [7:0]          keystates2;

    int n_vec = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    cpu_bus_ctrl_if bus ();

    always #5 clk = ~clk;

    cpu_bus_ctrl #(
        .RAM_AW    (RAM_AW),
        .BANK_BITS (BANK_BITS),
        .DMA_LEN   (DMA_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu          (bus),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .prg_addr     (prg_addr),
        .prg_dout     (prg_dout),
        .ppu_reg_cs   (ppu_reg_cs),
        .ppu_reg_addr (ppu_reg_addr),
        .ppu_reg_we   (ppu_reg_we),
        .ppu_reg_din  (ppu_reg_din),
        .ppu_reg_dout (ppu_reg_dout),
        .oam_we       (oam_we),
        .oam_addr     (oam_addr),
        .oam_din      (oam_din),
        .keystates    (keystates)
`ifdef CPU_BUS_CTRL_CTRL2_EN
        ,
        .keystates2   (keystates2)
`endif
    );

    // Synchronous RAM, PRG ROM and PPU register models, all 1-cycle read latency
    logic [7:0] mem [0:(1<<RAM_AW)-1];

    function automatic logic [7:0] prg_byte(input logic [PRG_AW-1:0] a);
        return a[7:0] ^ 8'(a[PRG_AW-1:14]);
    endfunction

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout     <= mem[ram_addr];
        prg_dout     <= prg_byte(prg_addr);
        ppu_reg_dout <= ppu_reg_cs ? 8'h80 : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_write(input logic [15:0] addr, input logic [7:0] data);
        bus.cpu_addr = addr;
        bus.cpu_we   = 1'b1;
        bus.cpu_din  = data;
        #1;
    endtask

    task automatic finish_write();
        @(posedge clk);
        #1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h5000;
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        drive_write(addr, data);
        finish_write();
    endtask

    task automatic drive_read(input logic [15:0] addr, input logic [7:0] exp, input string tag);
        bus.cpu_addr = addr;
        bus.cpu_we   = 1'b0;
        exp_q.push_back({8'h00, exp});
        tag_q.push_back(tag);
        #1;
    endtask

    task automatic finish_read();
        logic [15:0] e;
        string       t;
        @(posedge clk);
        #1;
        bus.cpu_addr = 16'h5000;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, {24'h0, bus.cpu_dout}, {16'h0, e});
    endtask

    task automatic cpu_read(input logic [15:0] addr, input logic [7:0] exp, input string tag);
        drive_read(addr, exp, tag);
        finish_read();
    endtask

    // Full DMA from page 2; optional CPU writes poked in while the core is stalled
    task automatic dma_run(input bit poke, input string tag);
        int stall    = 0;
        int pulses   = 0;
        int we_seen  = 0;
        logic [15:0] e;
        string       t;
        for (int i = 0; i < DMA_LEN; i++) begin
            exp_q.push_back({8'(i), 8'(i) ^ 8'hFF});
            tag_q.push_back(tag);
        end
        cpu_write(16'h4014, 8'h02);
        for (int cyc = 0; cyc < 1200; cyc++) begin
            if (poke) begin
                if (cyc == 10) begin
                    bus.cpu_addr = 16'h0000; bus.cpu_we = 1'b1; bus.cpu_din = 8'hCC;
                end else if (cyc == 11) begin
                    bus.cpu_addr = 16'h4014; bus.cpu_we = 1'b1; bus.cpu_din = 8'h03;
                end else if (cyc == 12) begin
                    bus.cpu_addr = 16'h5000; bus.cpu_we = 1'b0;
                end
            end
            #1;
            if (bus.cpu_rdy) break;
            stall++;
            if (ram_we || ppu_reg_we) we_seen++;
            if (oam_we) begin
                pulses++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    t = tag_q.pop_front();
                    check(t, {16'h0, oam_addr, oam_din}, {16'h0, e});
                end
            end
            @(posedge clk);
            #1;
        end
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h5000;
        check({tag, "_stall"}, stall, 1 + 2 * DMA_LEN);
        check({tag, "_pulses"}, pulses, DMA_LEN);
        check({tag, "_bus_we"}, we_seen, 0);
        check({tag, "_left"}, exp_q.size(), 0);
        exp_q.delete();
        tag_q.delete();
    endtask

    logic [7:0] ks;

    initial begin
        bus.cpu_addr = 16'h5000;
        bus.cpu_we   = 1'b0;
        bus.cpu_din  = 8'h00;
        keystates    = 8'h00;
        keystates2   = 8'h01;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", bus.cpu_rdy, 1);
        check("rst_dout", bus.cpu_dout, 8'h00);
        check("rst_oam_we", oam_we, 0);
        check("rst_ram_we", ram_we, 0);
        reset = 1'b0;

        // Mirrored RAM
        drive_write(16'h0805, 8'h5A);
        check("ram_wr_addr", ram_addr, 11'h005);
        check("ram_wr_we", ram_we, 1);
        finish_write();
        drive_read(16'h0005, 8'h5A, "ram_rd");
        check("ram_rd_addr", ram_addr, 11'h005);
        finish_read();

        // PRG banking
        cpu_write(16'h9000, 8'h02);
        drive_read(16'h8123, prg_byte(17'h08123), "prg_bank_rd");
        check("prg_bank_addr", prg_addr, 17'h08123);
        finish_read();
        drive_read(16'hC000, prg_byte(17'h1C000), "prg_last_rd");
        check("prg_last_addr", prg_addr, 17'h1C000);
        finish_read();

        // PPU window and open bus
        drive_read(16'h2002, 8'h80, "ppu_rd");
        check("ppu_cs", ppu_reg_cs, 1);
        check("ppu_addr", ppu_reg_addr, 3'd2);
        check("ppu_rd_we", ppu_reg_we, 0);
        finish_read();
        drive_write(16'h2001, 8'h1E);
        check("ppu_wr_we", ppu_reg_we, 1);
        check("ppu_wr_din", ppu_reg_din, 8'h1E);
        finish_write();
        drive_read(16'h5000, 8'h00, "open_rd");
        check("open_cs", ppu_reg_cs, 0);
        finish_read();

        // Controller: live reads while strobed, then the serial sequence
        keystates = 8'h80;
        cpu_write(16'h4016, 8'h01);
        cpu_read(16'h4016, 8'h00, "ctrl_strobe_lo");
        keystates = 8'h81;
        cpu_read(16'h4016, 8'h01, "ctrl_strobe_hi");
        cpu_write(16'h4016, 8'h00);
`ifdef CPU_BUS_CTRL_CTRL2_EN
        cpu_read(16'h4017, 8'h01, "ctrl2_rd");
`else
        cpu_read(16'h4017, 8'h00, "ctrl2_rd");
`endif
        ks = 8'h81;
        for (int k = 0; k < 9; k++) begin
            cpu_read(16'h4016, (k < 8) ? {7'b0, ks[k]} : 8'h01, $sformatf("ctrl_bit%0d", k));
        end

        // OAM DMA from a preloaded page, with CPU writes attempted mid-transfer
        cpu_write(16'h0000, 8'h33);
        for (int i = 0; i < 256; i++) begin
            cpu_write(16'h0200 + 16'(i), 8'(i) ^ 8'hFF);
        end
        dma_run(1'b1, "dma1");
        cpu_read(16'h0000, 8'h33, "dma_blocked_wr");
        cpu_read(16'h0200, 8'hFF, "dma_src_intact");

        // Reset in the middle of a transfer, then restart
        cpu_write(16'h4014, 8'h02);
        repeat (100) begin
            @(posedge clk);
            #1;
        end
        check("mid_dma_oam_we", oam_we, 1);
        check("mid_dma_rdy", bus.cpu_rdy, 0);
        reset = 1'b1;
        #1;
        check("rst_mid_rdy", bus.cpu_rdy, 1);
        check("rst_mid_oam_we", oam_we, 0);
        check("rst_mid_oam_addr", oam_addr, 8'h00);
        check("rst_mid_oam_din", oam_din, 8'h00);
        check("rst_mid_dout", bus.cpu_dout, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_read(16'h8123, prg_byte(17'h00123), "rst_bank_rd");
        check("rst_bank_addr", prg_addr, 17'h00123);
        finish_read();
        dma_run(1'b0, "dma2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
